// File: rtl/isa_pkg.sv
// isa_pkg: instruction field layout, format codes, loader FSM states and the field packer.
package isa_pkg;
  localparam int OPC_LSB = 26, OPC_W = 6;
  localparam int RD_LSB = 21, RD_W = 5;
  localparam int RT_LSB = 16, RT_W = 5;
  localparam int RS_LSB = 11, RS_W = 5;
  localparam int FUNCT_LSB = 0, FUNCT_W = 6;
  localparam int CONST_LSB = 0, CONST_W = 16;
  localparam logic FMT_R = 1'b0;
  localparam logic FMT_I = 1'b1;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;
  function automatic logic [31:0] encode(input logic fmt, input logic [OPC_W-1:0] opc,
                                         input logic [RD_W-1:0] rd, input logic [RT_W-1:0] rt,
                                         input logic [RS_W-1:0] rs, input logic [FUNCT_W-1:0] funct,
                                         input logic [CONST_W-1:0] cst);
    logic [31:0] w;
    w = '0;
    w[OPC_LSB +: OPC_W] = opc;
    w[RD_LSB +: RD_W] = rd;
    w[RT_LSB +: RT_W] = rt;
    if (fmt == FMT_I) w[CONST_LSB +: CONST_W] = cst;
    else begin
      w[RS_LSB +: RS_W] = rs;
      w[FUNCT_LSB +: FUNCT_W] = funct;
    end
    return w;
  endfunction
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: 32-bit synchronous FIFO with full/empty flags and a registered occupancy count.
module instr_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   din,
  output logic [31:0]   dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [31:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_d = do_push ? wr_q + AW'(1) : wr_q;
    rd_d = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout = mem_q[rd_q];
    count = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs instruction fields into words and streams them into instruction memory.
// Optional ENCODER_CHECKSUM_EN adds a running XOR checksum of the words written this session.
module instr_encoder_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_fmt,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rs,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_constant,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
`ifdef ENCODER_CHECKSUM_EN
  ,output logic [31:0]      checksum
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic push, pop, full, empty, active, has, sat, wr_done;
  logic [31:0] word, head;
  logic [CW:0] fcount;
`ifdef ENCODER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  assign checksum = sum_q;
`endif
  instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(word),
    .dout(head), .full(full), .empty(empty), .count(fcount)
  );
  always_comb begin
    word = encode(in_fmt, in_opcode, in_rd, in_rt, in_rs, in_funct, in_constant);
    in_ready = state_q == S_LOAD && !full;
    push = in_valid && in_ready;
    active = state_q == S_LOAD || state_q == S_DRAIN;
    // once 2^ADDR_W words are written, remaining words are popped and dropped
    sat = cnt_q[ADDR_W];
    has = active && !empty;
    mem_we = has && !sat;
    wr_done = mem_we && mem_ready;
    pop = has && (sat || mem_ready);
    mem_wdata = mem_we ? head : '0;
    mem_addr = ptr_q;
    busy = state_q != S_IDLE;
    done = state_q == S_DONE;
    overflow = ovf_q;
    word_count = cnt_q;
    state_d = state_q;
    ptr_d = wr_done ? ptr_q + ADDR_W'(1) : ptr_q;
    cnt_d = wr_done ? cnt_q + (ADDR_W+1)'(1) : cnt_q;
    ovf_d = ovf_q || (has && sat);
`ifdef ENCODER_CHECKSUM_EN
    sum_d = wr_done ? sum_q ^ head : sum_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        ptr_d = base_addr;
        cnt_d = '0;
        ovf_d = 1'b0;
`ifdef ENCODER_CHECKSUM_EN
        sum_d = '0;
`endif
      end
      S_LOAD: if (push && in_last) state_d = S_DRAIN;
      S_DRAIN: if (fcount == '0) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
`ifdef ENCODER_CHECKSUM_EN
      sum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
`ifdef ENCODER_CHECKSUM_EN
      sum_q <= sum_d;
`endif
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed checks of encoding, streaming, backpressure, wrap/overflow and reset.
module tb_instr_encoder_loader;
  logic clk = 0, rst_n = 0, start = 0, sel = 0, in_valid = 0, in_fmt = 0, in_last = 0, mem_ready = 1;
  logic [7:0] base_addr = 0;
  logic [5:0] in_opcode = 0, in_funct = 0;
  logic [4:0] in_rd = 0, in_rt = 0, in_rs = 0;
  logic [15:0] in_constant = 0;
  logic a_in_ready, a_mem_we, a_busy, a_done, a_overflow;
  logic [7:0] a_mem_addr;
  logic [31:0] a_mem_wdata;
  logic [8:0] a_word_count;
  logic b_in_ready, b_mem_we, b_busy, b_done, b_overflow;
  logic [1:0] b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic [2:0] b_word_count;
`ifdef ENCODER_CHECKSUM_EN
  logic [31:0] a_checksum, b_checksum;
`endif
  logic rdy, done_s, we_s;
  logic [7:0] addr_s;
  logic [31:0] wd_s;
  int n_vec = 0, n_bad = 0, cyc = 0;
  logic [31:0] lg_data[$];
  int lg_addr[$];
  int lg_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_encoder_loader #(.ADDR_W(8), .FIFO_DEPTH(4)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rt(in_rt), .in_rs(in_rs), .in_funct(in_funct), .in_constant(in_constant),
    .in_last(in_last), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_ready(mem_ready), .busy(a_busy), .done(a_done), .overflow(a_overflow),
    .word_count(a_word_count)
`ifdef ENCODER_CHECKSUM_EN
    , .checksum(a_checksum)
`endif
  );
  instr_encoder_loader #(.ADDR_W(2), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .base_addr(base_addr[1:0]),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rt(in_rt), .in_rs(in_rs), .in_funct(in_funct), .in_constant(in_constant),
    .in_last(in_last), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_ready(mem_ready), .busy(b_busy), .done(b_done), .overflow(b_overflow),
    .word_count(b_word_count)
`ifdef ENCODER_CHECKSUM_EN
    , .checksum(b_checksum)
`endif
  );

  assign rdy = sel ? b_in_ready : a_in_ready;
  assign done_s = sel ? b_done : a_done;
  assign we_s = sel ? b_mem_we : a_mem_we;
  assign addr_s = sel ? {6'b0, b_mem_addr} : a_mem_addr;
  assign wd_s = sel ? b_mem_wdata : a_mem_wdata;

  always @(negedge clk)
    if (rst_n && we_s && mem_ready) begin
      lg_data.push_back(wd_s);
      lg_addr.push_back(int'(addr_s));
      lg_cyc.push_back(cyc);
    end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    lg_data.delete();
    lg_addr.delete();
    lg_cyc.delete();
  endtask

  task automatic do_start(input logic [7:0] b);
    @(negedge clk);
    base_addr = b;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send(input logic fmt, input logic [5:0] opc, input logic [4:0] rd, input logic [4:0] rt,
                      input logic [4:0] rs, input logic [5:0] fn, input logic [15:0] c, input logic last);
    int t = 0;
    in_fmt = fmt; in_opcode = opc; in_rd = rd; in_rt = rt; in_rs = rs;
    in_funct = fn; in_constant = c; in_last = last; in_valid = 1;
    while (!rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("send_timeout", {63'b0, rdy}, 1);
    @(negedge clk);
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done_s && t < 80) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", {63'b0, done_s}, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_in_ready", a_in_ready, 0);
    check("rst_mem_we", a_mem_we, 0);
    check("rst_mem_addr", a_mem_addr, 0);
    check("rst_mem_wdata", a_mem_wdata, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_overflow", a_overflow, 0);
    check("rst_word_count", a_word_count, 0);
    rst_n = 1;
    @(negedge clk);
    check("idle_in_ready", a_in_ready, 0);

    // single R-type word
    clr();
    do_start(8'h10);
    check("t1_busy", a_busy, 1);
    check("t1_in_ready", a_in_ready, 1);
    send(0, 6'd0, 5'd8, 5'd9, 5'd16, 6'h24, 16'h0, 1);
    check("t1_we_next", a_mem_we, 1);
    check("t1_wdata", a_mem_wdata, 32'h01098024);
    check("t1_addr", a_mem_addr, 8'h10);
    wait_done();
    check("t1_nwrites", lg_data.size(), 1);
    check("t1_wc", a_word_count, 1);
    @(negedge clk);
    check("t1_done_pulse", a_done, 0);
    check("t1_idle", a_busy, 0);

    // back-to-back R, R, I
    clr();
    do_start(8'h00);
    send(0, 6'd0, 5'd8, 5'd9, 5'd16, 6'h24, 16'h0, 0);
    send(0, 6'd0, 5'd8, 5'd9, 5'd18, 6'h22, 16'h0, 0);
    send(1, 6'h08, 5'd1, 5'd2, 5'd31, 6'h3f, 16'h0005, 1);
    wait_done();
    check("t2_nwrites", lg_data.size(), 3);
    check("t2_d0", lg_data[0], 32'h01098024);
    check("t2_d1", lg_data[1], 32'h01099022);
    check("t2_d2", lg_data[2], 32'h20220005);
    check("t2_a0", lg_addr[0], 0);
    check("t2_a2", lg_addr[2], 2);
    check("t2_consec", lg_cyc[2] - lg_cyc[0], 2);
    check("t2_wc", a_word_count, 3);

    // backpressure with a 6-word stream
    clr();
    mem_ready = 0;
    do_start(8'h40);
    for (int k = 1; k <= 4; k++) send(1, 6'h08, 5'd1, 5'd2, 5'd0, 6'd0, 16'(k), 0);
    check("t3_full_ready", a_in_ready, 0);
    check("t3_we", a_mem_we, 1);
    check("t3_addr", a_mem_addr, 8'h40);
    check("t3_wdata", a_mem_wdata, 32'h20220001);
    repeat (3) @(negedge clk);
    check("t3_hold_we", a_mem_we, 1);
    check("t3_hold_addr", a_mem_addr, 8'h40);
    check("t3_hold_wdata", a_mem_wdata, 32'h20220001);
    check("t3_hold_nwrites", lg_data.size(), 0);
    mem_ready = 1;
    send(1, 6'h08, 5'd1, 5'd2, 5'd0, 6'd0, 16'd5, 0);
    send(1, 6'h08, 5'd1, 5'd2, 5'd0, 6'd0, 16'd6, 1);
    wait_done();
    check("t3_nwrites", lg_data.size(), 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t3_d%0d", k), lg_data[k], 32'h20220001 + 32'(k));
      check($sformatf("t3_a%0d", k), lg_addr[k], 8'h40 + k);
    end
    check("t3_wc", a_word_count, 6);
    check("t3_no_ovf", a_overflow, 0);

    // wrap and overflow on the ADDR_W=2 instance
    clr();
    sel = 1;
    do_start(8'h03);
    for (int k = 1; k <= 5; k++) send(1, 6'h08, 5'd1, 5'd2, 5'd0, 6'd0, 16'(k), k == 5);
    wait_done();
    check("t4_nwrites", lg_data.size(), 4);
    check("t4_a0", lg_addr[0], 3);
    check("t4_a1", lg_addr[1], 0);
    check("t4_a2", lg_addr[2], 1);
    check("t4_a3", lg_addr[3], 2);
    check("t4_d3", lg_data[3], 32'h20220004);
    check("t4_ovf", b_overflow, 1);
    check("t4_wc", b_word_count, 4);
    @(negedge clk);
    sel = 0;

    // reset mid-session with two words buffered
    clr();
    mem_ready = 0;
    do_start(8'h80);
    send(0, 6'd0, 5'd8, 5'd9, 5'd16, 6'h24, 16'h0, 0);
    send(0, 6'd0, 5'd8, 5'd9, 5'd18, 6'h22, 16'h0, 0);
    check("t5_pre_we", a_mem_we, 1);
    rst_n = 0;
    @(negedge clk);
    check("t5_busy", a_busy, 0);
    check("t5_in_ready", a_in_ready, 0);
    check("t5_we", a_mem_we, 0);
    check("t5_addr", a_mem_addr, 0);
    check("t5_wdata", a_mem_wdata, 0);
    check("t5_done", a_done, 0);
    check("t5_wc", a_word_count, 0);
    rst_n = 1;
    mem_ready = 1;
    clr();
    do_start(8'h20);
    send(1, 6'h08, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005, 1);
    wait_done();
    check("t5_nwrites", lg_data.size(), 1);
    check("t5_a0", lg_addr[0], 8'h20);
    check("t5_d0", lg_data[0], 32'h20220005);
    check("t5_wc2", a_word_count, 1);

`ifdef ENCODER_CHECKSUM_EN
    clr();
    do_start(8'h00);
    check("t6_cleared", a_checksum, 0);
    send(0, 6'd0, 5'd8, 5'd9, 5'd16, 6'h24, 16'h0, 0);
    send(0, 6'd0, 5'd8, 5'd9, 5'd18, 6'h22, 16'h0, 1);
    wait_done();
    check("t6_checksum", a_checksum, 32'h00001006);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
